// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared mode encodings and PWM width for the multi-channel LED blinker
// Purpose : constants and types shared by blink_multi and blink_chan.
// Contents: PWM_W (PWM counter / duty width), mode_t (per-channel mode encoding).
// Macro   : BLINK_BREATHE_EN selects the meaning of MODE_EXT (breathe when defined, steady on otherwise).
package blink_pkg;

  localparam int PWM_W = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_PWM   = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_EXT   = 2'b11
  } mode_t;

endpackage

// File: rtl/blink_chan.sv
// rtl/blink_chan.sv - one LED channel: mode, double-buffered duty, optional breathe state, LED register
// Purpose : holds all per-channel state and produces the registered LED drive.
// Ports   : i_clk        clock (rising edge)
//           i_rst        synchronous active-low reset
//           i_en         global run enable; LED forced low while 0
//           i_we         config write strobe already decoded for this channel
//           i_mode       new channel mode
//           i_duty       new duty, loaded into the shadow register
//           i_pwm_cnt    shared PWM counter
//           i_blink      shared blink phase
//           i_frame_wrap shared end-of-frame pulse
//           o_led        registered LED drive
// Macro   : BLINK_BREATHE_EN -- when defined MODE_EXT breathes, otherwise MODE_EXT is steady on
//           and no breathe registers exist.
module blink_chan
  import blink_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_we,
  input  mode_t            i_mode,
  input  logic [PWM_W-1:0] i_duty,
  input  logic [PWM_W-1:0] i_pwm_cnt,
  input  logic             i_blink,
  input  logic             i_frame_wrap,
  output logic             o_led
);

  mode_t            r_mode;
  logic [PWM_W-1:0] r_duty_shadow;
  logic [PWM_W-1:0] r_duty_act;
  logic             r_led;
  logic             w_ext;
  logic             w_drive;

  // Shadow is written at any time; the active duty only changes on a frame
  // boundary. On a write coinciding with a wrap, the nonblocking update makes
  // the wrap take the old shadow and the new value waits for the next wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_mode        <= MODE_OFF;
      r_duty_shadow <= '0;
      r_duty_act    <= '0;
      r_led         <= 1'b0;
    end else begin
      if (i_we) begin
        r_mode        <= i_mode;
        r_duty_shadow <= i_duty;
      end
      if (i_frame_wrap) begin
        r_duty_act <= r_duty_shadow;
      end
      r_led <= i_en & w_drive;
    end
  end

`ifdef BLINK_BREATHE_EN
  logic [PWM_W-1:0] r_level;
  logic             r_dir_dn;

  // Triangle 0..255..0 stepping once per frame. Entering MODE_EXT from any
  // other mode restarts at level 0 counting up.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_level  <= '0;
      r_dir_dn <= 1'b0;
    end else if (i_we && (i_mode == MODE_EXT) && (r_mode != MODE_EXT)) begin
      r_level  <= '0;
      r_dir_dn <= 1'b0;
    end else if ((r_mode == MODE_EXT) && i_frame_wrap) begin
      if (!r_dir_dn) begin
        if (r_level == '1) begin
          r_dir_dn <= 1'b1;
          r_level  <= r_level - PWM_W'(1);
        end else begin
          r_level  <= r_level + PWM_W'(1);
        end
      end else begin
        if (r_level == '0) begin
          r_dir_dn <= 1'b0;
          r_level  <= r_level + PWM_W'(1);
        end else begin
          r_level  <= r_level - PWM_W'(1);
        end
      end
    end
  end

  assign w_ext = (i_pwm_cnt < r_level);
`else
  assign w_ext = 1'b1;
`endif

  always_comb begin
    w_drive = 1'b0;
    case (r_mode)
      MODE_OFF:   w_drive = 1'b0;
      MODE_PWM:   w_drive = (i_pwm_cnt < r_duty_act);
      MODE_BLINK: w_drive = i_blink;
      MODE_EXT:   w_drive = w_ext;
      default:    w_drive = 1'b0;
    endcase
  end

  assign o_led = r_led;

endmodule

// File: rtl/blink_multi.sv
// rtl/blink_multi.sv - multi-channel LED blinker top: prescaler, shared PWM/frame counters, channel array
// Purpose : generates the PWM tick, PWM counter and frame counter shared by NUM_CH channels and
//           decodes configuration writes to the addressed channel.
// Ports   : blink_clk  clock (rising edge)
//           rst        synchronous active-low reset
//           en         global run enable; counters hold and LEDs go low while 0
//           cfg_we     config write strobe (single cycle)
//           cfg_addr   target channel; writes to indices >= NUM_CH are dropped
//           cfg_mode   channel mode
//           cfg_duty   channel PWM duty
//           led        registered LED drive, one bit per channel
// Macro   : BLINK_BREATHE_EN -- enables the breathe behaviour of MODE_EXT in every channel.
module blink_multi
  import blink_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int PRESC_DIV = 1024,
  parameter int BLINK_BIT = 4
) (
  input  logic              blink_clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [1:0]        cfg_mode,
  input  logic [PWM_W-1:0]  cfg_duty,
  output logic [NUM_CH-1:0] led
);

  localparam int PW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [7:0]       r_frame_cnt;
  logic             w_tick;
  logic             w_frame_wrap;
  logic             w_blink;

  assign w_tick       = en && (r_presc == PRESC_LAST);
  assign w_frame_wrap = w_tick && (r_pwm_cnt == '1);
  // Mask-and-reduce picks frame_cnt[BLINK_BIT] while keeping every counter bit in use.
  assign w_blink      = |(r_frame_cnt & (8'd1 << BLINK_BIT));

  always_ff @(posedge blink_clk) begin
    if (!rst) begin
      r_presc     <= '0;
      r_pwm_cnt   <= '0;
      r_frame_cnt <= '0;
    end else if (w_tick) begin
      r_presc   <= '0;
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      if (w_frame_wrap) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end else if (en) begin
      r_presc <= r_presc + PW'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    logic w_sel;
    // Only indices below NUM_CH can ever match, so out-of-range writes touch nothing.
    assign w_sel = cfg_we && (cfg_addr == 5'(g));

    blink_chan u_chan (
      .i_clk        (blink_clk),
      .i_rst        (rst),
      .i_en         (en),
      .i_we         (w_sel),
      .i_mode       (mode_t'(cfg_mode)),
      .i_duty       (cfg_duty),
      .i_pwm_cnt    (r_pwm_cnt),
      .i_blink      (w_blink),
      .i_frame_wrap (w_frame_wrap),
      .o_led        (led[g])
    );
  end

endmodule
